apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

Zero-wait-state APB (v2, no PREADY/PSLVERR) slave exposing a bank of general-purpose read/write word registers. Sits on the peripheral bus behind the bus bridge and serves as the register target for interactive register debug. Writes commit at the end of the access phase. Read data is registered in the setup phase and held stable through the access phase.

## Interface
- DATAW, 32, data bus and register width in bits
- ADDRW, 32, address bus width in bits
- NREGS, 16, number of registers; power of two, ≥2, NREGS*4 ≤ 2^ADDRW

Ports:
- clk  in  1  bus clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- paddr  in  ADDRW  byte address
- pwrite  in  1  1 = write, 0 = read
- psel  in  1  slave select
- penable  in  1  access-phase strobe
- pwdata  in  DATAW  write data
- prdata  out  DATAW  read data, registered

## Operation
- Register array: reg[0..NREGS-1], each DATAW bits, all read/write, reset to 0.
- Address decode: word-aligned. paddr[1:0] ignored. Index = paddr[log2(NREGS)+1:2].
- In-range means all paddr bits above bit log2(NREGS)+1 are zero, i.e. paddr < NREGS*4 (0x00–0x3C for the default).
- Out-of-range writes are dropped; no register changes.
- Out-of-range reads return 0.
- Setup phase: psel=1, penable=0.
- Access phase: psel=1, penable=1.
- Write: on the clk edge with psel & penable & pwrite, in-range reg[index] <= pwdata. Full-word write; no byte strobes.
- Read: on the clk edge with psel & !penable & !pwrite, prdata <= in-range ? reg[index] : 0.
- prdata holds its last loaded value at all other times. It is not cleared after a transfer and is not updated by writes.
- psel=0: no state change, penable ignored.
- penable=1 with psel=0: ignored.
- Access without a preceding setup cycle: a write still commits; a read returns the previously held prdata.

## Timing
- Reset: asserting rst immediately clears every reg[] and prdata to 0, independent of clk.
- A transfer in progress when rst asserts is aborted and its write is not committed.
- While rst is high, all bus inputs are ignored.
- The first transfer is accepted on the first rising edge after rst deasserts.
- Write latency: new value visible in the array on the same edge that samples the access phase. A read whose setup phase follows on the next cycle returns the new value.
- Read latency: prdata is valid after the setup-phase edge and stable through the whole access phase and beyond, until the next read setup.
- No wait states: every transfer is exactly 2 cycles (setup + access).
- Back-to-back transfers: a new setup may directly follow an access cycle.
- pwdata, paddr, and pwrite are only sampled when psel=1.

## Test plan
- Reset: hold rst high for 5 cycles, then read 0x00, 0x04, and 0x3C. Each returns 0x00000000.
- Write/readback: write 0xDEADBEEF to 0x08 and 0x12345678 to 0x3C, then read both. Each returns the written value; 0x04 still reads 0.
- Aliasing and decode: write 0xA5A5A5A5 to 0x0B, then read 0x08 and 0x09; both return 0xA5A5A5A5. Write 0xFFFFFFFF to 0x40, then read 0x40 and 0x00; both return 0, and all in-range registers are unchanged.
- Back-to-back: write 0x1 to 0x10, immediately followed by a read of 0x10. The read returns 0x00000001. prdata stays 0x00000001 during 3 idle cycles that follow.
- Async reset mid-transfer: set reg[2]=0x55; start a write of 0xAA to 0x08 and pulse rst between clk edges during the access phase. prdata and reg[2] become 0 immediately, and a later read of 0x08 returns 0.
- Idle and protocol noise: toggle penable with psel=0 and random paddr/pwdata for 20 cycles. No register or prdata changes.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// Zero-wait-state APB v2 slave with NREGS general-purpose read/write word registers.
// Writes commit on the access-phase edge; read data loads on the setup-phase edge and is held.
module apb_slave_regfile #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] paddr,
  input  logic             pwrite,
  input  logic             psel,
  input  logic             penable,
  input  logic [DATAW-1:0] pwdata,
  output logic [DATAW-1:0] prdata
);

  localparam int IDXW = $clog2(NREGS);

  logic [DATAW-1:0] regs_q [NREGS];
  logic [DATAW-1:0] prdata_q, prdata_d;
  logic [IDXW-1:0]  idx;
  logic             in_range;
  logic             wr_en;
  logic             rd_en;
  logic             unused_addr_lsb;

  // Byte-lane bits carry no meaning for full-word registers.
  assign unused_addr_lsb = ^paddr[1:0];

  assign idx      = paddr[IDXW+1:2];
  assign in_range = (paddr >> (IDXW + 2)) == '0;
  assign wr_en    = psel & penable & pwrite & in_range;
  assign rd_en    = psel & ~penable & ~pwrite;

  // NOTE: combinational next-state logic uses blocking '=' with a default first,
  // so every path assigns prdata_d and no latch is inferred.
  always_comb begin
    prdata_d = prdata_q;
    if (rd_en) begin
      prdata_d = in_range ? regs_q[idx] : '0;
    end
  end

  // NOTE: the register array is architecturally visible and must read 0 after
  // reset, so it is reset explicitly rather than left as an uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      prdata_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[idx] <= pwdata;
      end
      prdata_q <= prdata_d;
    end
  end

  assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: stimulus pushes expected read data, a monitor
// pops and compares during each read access phase against an array-based register model.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [16];
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  apb_slave_regfile #(.DATAW(32), .ADDRW(32), .NREGS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .prdata  (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte address space, only the first 64 bytes are backed.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a < 32'd64) ? model[a / 4] : 32'd0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'd64) model[a / 4] = d;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    last_rd = 32'd0;
  endtask

  // Tasks start at posedge+1 and leave the bus in its access phase so a
  // following transfer can begin back-to-back.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    ref_write(a, d);
    @(posedge clk); #1;
  endtask

  task automatic apb_read(input logic [31:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    last_rd = ref_read(a);
    exp_q.push_back(last_rd);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_hold", prdata, last_rd);
      @(posedge clk); #1;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) apb_read(32'(i * 4));
    idle(1);
  endtask

  // Monitor: during every read access phase the held prdata must match the scoreboard.
  always @(negedge clk) begin
    if (!rst && psel && penable && !pwrite) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("read_data", prdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ref_reset();

    // Reset
    repeat (5) @(posedge clk);
    check("reset_prdata", prdata, 32'd0);
    #1 rst = 1'b0;
    apb_read(32'h00);
    apb_read(32'h04);
    apb_read(32'h3C);
    idle(1);

    // Write / readback
    apb_write(32'h08, 32'hDEADBEEF);
    apb_write(32'h3C, 32'h12345678);
    apb_read(32'h08);
    apb_read(32'h3C);
    apb_read(32'h04);
    idle(1);

    // Aliasing and decode
    apb_write(32'h0B, 32'hA5A5A5A5);
    apb_read(32'h08);
    apb_read(32'h09);
    apb_write(32'h40, 32'hFFFFFFFF);
    apb_read(32'h40);
    apb_read(32'h00);
    read_all();

    // Back-to-back write then read, then hold through idle
    apb_write(32'h10, 32'h1);
    apb_read(32'h10);
    idle(3);
    check("b2b_value", last_rd, 32'h1);

    // Async reset during a write access phase
    apb_write(32'h08, 32'h55);
    apb_read(32'h08);
    idle(1);
    check("pre_reset_prdata", prdata, 32'h55);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    check("async_rst_prdata", prdata, 32'd0);
    ref_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    apb_read(32'h08);
    idle(1);
    read_all();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 127);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) apb_write(a, d);
      else apb_read(a);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

    // Protocol noise with psel low
    for (int i = 0; i < 20; i++) begin
      psel = 1'b0;
      penable = 1'($urandom_range(0, 1));
      pwrite = 1'($urandom_range(0, 1));
      paddr = $urandom_range(0, 127);
      pwdata = $urandom;
      @(negedge clk);
      check("noise_prdata", prdata, last_rd);
      @(posedge clk); #1;
    end
    read_all();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
